simple_phase_seq: RTL and testbench
===================================

// Module: simple_phase_seq
// PURPOSE
//  Consumer of the 2-bit IF/ID/EX/WB phase count. Tracks the phase stream.
//  Issues per-phase control strobes for the simple ISA datapath.
//  Owns the PC and the instruction register (IR).
//  Detects phase-sequence errors and resynchronises.
//  Sits between the phase counter, instruction memory, register file and ALU.
// PARAMETERS
//  IW  16  instruction width; opcode=ir[IW-1:IW-4], rd=ir[11:8], rs_a=ir[7:4], rs_b=ir[3:0], imm=ir[7:0]
//  AW  8   PC/imem address width; legal range 1..12; jump target = ir[AW-1:0]
// PORTS
//  clk         in   1   clock
//  resetn      in   1   reset, asynchronous, active-low
//  phase       in   2   0=IF 1=ID 2=EX 3=WB, free-running count
//  imem_rdata  in   IW  instruction word, valid when imem_ready=1
//  imem_ready  in   1   imem has data this IF cycle
//  zero_flag   in   1   ALU zero flag, sampled in EX
//  imem_req    out  1   fetch request (addr = pc)
//  pc          out  AW  program counter
//  ir          out  IW  instruction register
//  rf_rd_en    out  1   register-file read strobe (ID)
//  rs_a,rs_b   out  4   read indices
//  alu_en      out  1   ALU strobe (EX)
//  alu_op      out  2   00=ADD 01=SUB (others reserved, never driven)
//  rf_wr_en    out  1   register-file write strobe (WB)
//  rf_wr_idx   out  4   write index
//  rf_wr_sel   out  1   0=ALU result, 1=imm
//  imm         out  8   immediate
//  halted      out  1   level, sticky
//  sync_err    out  1   1-cycle pulse, phase stream out of sequence
//  illegal_op  out  1   1-cycle pulse, undefined opcode decoded
//  retire_cnt  out  16  retired-instruction count, wraps
// BEHAVIOUR
//  Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 LDI, 4 JMP, 5 BEQZ, F HALT; all others illegal.
//  Reset values: every output is 0; state=SYNC; valid=0; exp_ph=0.
//  Strobe timing:
//   - Strobes are combinational from (state, phase, ir, valid), so strobe latency is 0.
//   - Registers update on the clk edge that closes each phase.
//  FSM states: SYNC, RUN, HALT.
//   - SYNC: all strobes are 0 except for the IF case below.
//   - SYNC with phase=0: behave as RUN/IF for that cycle, then go to RUN with exp_ph=1.
//   - RUN: exp_ph advances by +1 mod 4 every cycle.
//   - RUN with phase!=exp_ph: suppress all strobes that cycle.
//     Next edge: sync_err=1, valid<=0, state<=SYNC. PC is unchanged.
//   - HALT: all strobes are 0 and halted=1. Only reset exits HALT.
//  IF (phase 0):
//   - imem_req=1.
//   - At the edge with imem_ready=1: ir<=imem_rdata, valid<=1.
//   - At the edge with imem_ready=0: valid<=0 (bubble). IR is held.
//  ID (phase 1), only if valid:
//   - rf_rd_en=1; rs_a/rs_b from ir.
//   - Illegal opcode: illegal_op pulses at the ID edge, valid<=0, and the instruction is dropped.
//  EX (phase 2), only if valid:
//   - ADD/SUB: alu_en=1, alu_op=00 for ADD, 01 for SUB.
//   - BEQZ: take<=zero_flag at the EX edge.
//  WB (phase 3), only if valid:
//   - ADD/SUB: rf_wr_en=1, rf_wr_sel=0, rf_wr_idx=rd.
//   - LDI: rf_wr_en=1, rf_wr_sel=1, imm=ir[7:0].
//  WB edge, PC update:
//   - JMP, or BEQZ with take=1: pc<=ir[AW-1:0].
//   - HALT: pc held, state<=HALT.
//   - Any other valid instruction: pc<=pc+1, wrapping 2^AW-1 -> 0.
//   - Bubble or dropped instruction: pc held, retire_cnt held.
//  retire_cnt: +1 at the WB edge for every valid instruction, including NOP, JMP and HALT.
//  Precedence: a sync error overrides every action in that cycle, including a WB retire.
//  Reset mid-instruction: asynchronous return to reset values. The in-flight instruction is lost.
// TESTING
//  1. Reset release with phase from 0 and program {LDI r1,5; ADD r2,r1,r1} ->
//     rf_wr_en at cycles 3 and 7; pc 0->1->2; retire_cnt=2.
//  2. imem_ready=0 in the cycle-4 IF -> no strobes cycles 5-7; pc stays 1; retire_cnt +0; next IF refetches addr 1.
//  3. BEQZ 0x20 twice, zero_flag=1 then 0 -> pc=0x20, then pc=0x21.
//     JMP 0xFF, then NOP at 0xFF -> pc wraps to 0x00.
//  4. Phase skips 1->3 mid-ADD -> sync_err pulse; no rf_wr_en; pc unchanged.
//     Then resyncs at the next phase=0 and fetches the same pc.
//  5. Opcode 0x7 -> illegal_op pulse at the ID edge; no alu_en/rf_wr_en; pc unchanged.
//     HALT -> halted=1, pc frozen, all strobes 0 for more than 20 cycles.
//  6. resetn asserted during EX of SUB -> all outputs 0 immediately; after release, refetch from pc=0.

Source files
------------

// File: rtl/simple_phase_seq.sv
// simple_phase_seq: phase-stream tracker and control sequencer for the simple ISA.
// Owns PC and IR, issues per-phase strobes, detects out-of-sequence phases.
module simple_phase_seq #(
  parameter int unsigned IW = 16,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [1:0]    phase,
  input  logic [IW-1:0] imem_rdata,
  input  logic          imem_ready,
  input  logic          zero_flag,
  output logic          imem_req,
  output logic [AW-1:0] pc,
  output logic [IW-1:0] ir,
  output logic          rf_rd_en,
  output logic [3:0]    rs_a,
  output logic [3:0]    rs_b,
  output logic          alu_en,
  output logic [1:0]    alu_op,
  output logic          rf_wr_en,
  output logic [3:0]    rf_wr_idx,
  output logic          rf_wr_sel,
  output logic [7:0]    imm,
  output logic          halted,
  output logic          sync_err,
  output logic          illegal_op,
  output logic [15:0]   retire_cnt
);

  localparam int unsigned RCW = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_BEQZ = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] PH_IF = 2'd0;
  localparam logic [1:0] PH_ID = 2'd1;
  localparam logic [1:0] PH_EX = 2'd2;
  localparam logic [1:0] PH_WB = 2'd3;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [1:0]       exp_ph_q, exp_ph_n;
  logic             valid_q, valid_n;
  logic             take_q, take_n;
  logic [AW-1:0]    pc_q, pc_n;
  logic [IW-1:0]    ir_q, ir_n;
  logic             halted_q, halted_n;
  logic             sync_err_q, sync_err_n;
  logic             illegal_q, illegal_n;
  logic [RCW-1:0]   retire_q, retire_n;
  logic             active;
  logic [3:0]       op;
  logic             op_legal;

  assign op = ir_q[IW-1 -: 4];

  // Opcode legality decode
  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_LDI, OP_JMP, OP_BEQZ, OP_HALT: op_legal = 1'b1;
      default:                                                 op_legal = 1'b0;
    endcase
  end

  // State/datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_SYNC;
      exp_ph_q   <= 2'd0;
      valid_q    <= 1'b0;
      take_q     <= 1'b0;
      pc_q       <= '0;
      ir_q       <= '0;
      halted_q   <= 1'b0;
      sync_err_q <= 1'b0;
      illegal_q  <= 1'b0;
      retire_q   <= '0;
    end else begin
      state_q    <= state_n;
      exp_ph_q   <= exp_ph_n;
      valid_q    <= valid_n;
      take_q     <= take_n;
      pc_q       <= pc_n;
      ir_q       <= ir_n;
      halted_q   <= halted_n;
      sync_err_q <= sync_err_n;
      illegal_q  <= illegal_n;
      retire_q   <= retire_n;
    end
  end

  // Next-state, register updates and per-phase strobes
  always_comb begin
    state_n    = state_q;
    exp_ph_n   = exp_ph_q;
    valid_n    = valid_q;
    take_n     = take_q;
    pc_n       = pc_q;
    ir_n       = ir_q;
    halted_n   = halted_q;
    sync_err_n = 1'b0;
    illegal_n  = 1'b0;
    retire_n   = retire_q;
    active     = 1'b0;
    imem_req   = 1'b0;
    rf_rd_en   = 1'b0;
    rs_a       = 4'd0;
    rs_b       = 4'd0;
    alu_en     = 1'b0;
    alu_op     = 2'b00;
    rf_wr_en   = 1'b0;
    rf_wr_idx  = 4'd0;
    rf_wr_sel  = 1'b0;
    imm        = 8'd0;

    case (state_q)
      ST_SYNC: begin
        // Lock onto the stream at the first IF seen
        if (phase == PH_IF) begin
          active   = 1'b1;
          state_n  = ST_RUN;
          exp_ph_n = 2'd1;
        end
      end
      ST_RUN: begin
        // An unexpected phase kills the cycle, including any WB retire
        if (phase != exp_ph_q) begin
          sync_err_n = 1'b1;
          valid_n    = 1'b0;
          state_n    = ST_SYNC;
          exp_ph_n   = 2'd0;
        end else begin
          active   = 1'b1;
          exp_ph_n = exp_ph_q + 2'd1;
        end
      end
      ST_HALT: begin
        halted_n = 1'b1;
      end
      default: begin
        state_n = ST_SYNC;
      end
    endcase

    if (active) begin
      case (phase)
        PH_IF: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_n    = imem_rdata;
            valid_n = 1'b1;
          end else begin
            valid_n = 1'b0;
          end
        end
        PH_ID: begin
          if (valid_q) begin
            rf_rd_en = 1'b1;
            rs_a     = ir_q[7:4];
            rs_b     = ir_q[3:0];
            if (!op_legal) begin
              illegal_n = 1'b1;
              valid_n   = 1'b0;
            end
          end
        end
        PH_EX: begin
          if (valid_q) begin
            if (op == OP_ADD || op == OP_SUB) begin
              alu_en = 1'b1;
              alu_op = (op == OP_SUB) ? 2'b01 : 2'b00;
            end
            if (op == OP_BEQZ) begin
              take_n = zero_flag;
            end
          end
        end
        PH_WB: begin
          if (valid_q) begin
            if (op == OP_ADD || op == OP_SUB) begin
              rf_wr_en  = 1'b1;
              rf_wr_sel = 1'b0;
              rf_wr_idx = ir_q[11:8];
            end else if (op == OP_LDI) begin
              rf_wr_en  = 1'b1;
              rf_wr_sel = 1'b1;
              rf_wr_idx = ir_q[11:8];
              imm       = ir_q[7:0];
            end
            retire_n = retire_q + RCW'(1);
            if (op == OP_JMP || (op == OP_BEQZ && take_q)) begin
              pc_n = ir_q[AW-1:0];
            end else if (op == OP_HALT) begin
              state_n  = ST_HALT;
              halted_n = 1'b1;
            end else begin
              pc_n = pc_q + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end

    // Strobes read as idle while reset is held
    if (!resetn) begin
      imem_req  = 1'b0;
      rf_rd_en  = 1'b0;
      rs_a      = 4'd0;
      rs_b      = 4'd0;
      alu_en    = 1'b0;
      alu_op    = 2'b00;
      rf_wr_en  = 1'b0;
      rf_wr_idx = 4'd0;
      rf_wr_sel = 1'b0;
      imm       = 8'd0;
    end
  end

  assign pc         = pc_q;
  assign ir         = ir_q;
  assign halted     = halted_q;
  assign sync_err   = sync_err_q;
  assign illegal_op = illegal_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_simple_phase_seq.sv
// Self-checking bench for simple_phase_seq: directed scenarios plus randomized
// phase streams, checked against an instruction-level reference model.
module tb_simple_phase_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  phase;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic        zero_flag;
  logic        imem_req;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic        rf_rd_en;
  logic [3:0]  rs_a, rs_b;
  logic        alu_en;
  logic [1:0]  alu_op;
  logic        rf_wr_en;
  logic [3:0]  rf_wr_idx;
  logic        rf_wr_sel;
  logic [7:0]  imm;
  logic        halted, sync_err, illegal_op;
  logic [15:0] retire_cnt;

  simple_phase_seq #(.IW(16), .AW(8)) dut (
    .clk(clk), .resetn(resetn), .phase(phase), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .zero_flag(zero_flag), .imem_req(imem_req),
    .pc(pc), .ir(ir), .rf_rd_en(rf_rd_en), .rs_a(rs_a), .rs_b(rs_b),
    .alu_en(alu_en), .alu_op(alu_op), .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx),
    .rf_wr_sel(rf_wr_sel), .imm(imm), .halted(halted), .sync_err(sync_err),
    .illegal_op(illegal_op), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem [256];

  // Reference model: where the machine is in the instruction it is executing
  bit          m_locked;   // following the phase stream
  int          m_nxt;      // phase the stream must show next
  bit          m_valid;    // current instruction still alive
  logic [15:0] m_ir;
  int          m_pc;
  bit          m_take;
  int          m_ret;
  bit          m_halted;
  bit          m_sync_e;
  bit          m_ill;
  int          tb_ph;      // free-running phase counter value for next cycle
  int          halt_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_nxt = 0; m_valid = 0; m_ir = 16'h0; m_pc = 0; m_take = 0;
    m_ret = 0; m_halted = 0; m_sync_e = 0; m_ill = 0; tb_ph = 0; halt_cycles = 0;
  endtask

  function automatic bit legal(input int op);
    return (op <= 5) || (op == 15);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_strobes"}, 32'({imem_req, rf_rd_en, rs_a, rs_b, alu_en, alu_op,
                                rf_wr_en, rf_wr_idx, rf_wr_sel, imm}), 32'd0);
    chk({tag, "_regs"}, 32'({pc, ir}), 32'd0);
    chk({tag, "_flags"}, 32'({halted, sync_err, illegal_op, retire_cnt}), 32'd0);
  endtask

  // One clock: drive at negedge, check strobes, clock, check registers, return at negedge
  task automatic step(input int ph, input bit rdy, input bit zf);
    bit act;
    int op;
    logic        e_req, e_rd, e_alu, e_wr, e_sel;
    logic [3:0]  e_rsa, e_rsb, e_idx;
    logic [1:0]  e_aop;
    logic [7:0]  e_imm;
    phase      = 2'(ph);
    imem_ready = rdy;
    zero_flag  = zf;
    imem_rdata = mem[m_pc];
    #1;
    op  = int'(m_ir[15:12]);
    act = !m_halted && (m_locked ? (ph == m_nxt) : (ph == 0));
    e_req = act && ph == 0;
    e_rd  = act && ph == 1 && m_valid;
    e_rsa = e_rd ? m_ir[7:4] : 4'd0;
    e_rsb = e_rd ? m_ir[3:0] : 4'd0;
    e_alu = act && ph == 2 && m_valid && (op == 1 || op == 2);
    e_aop = (e_alu && op == 2) ? 2'b01 : 2'b00;
    e_wr  = act && ph == 3 && m_valid && (op == 1 || op == 2 || op == 3);
    e_sel = e_wr && op == 3;
    e_idx = e_wr ? m_ir[11:8] : 4'd0;
    e_imm = e_sel ? m_ir[7:0] : 8'd0;
    chk("strobes", 32'({imem_req, rf_rd_en, rs_a, rs_b, alu_en, alu_op, rf_wr_en, rf_wr_idx, rf_wr_sel, imm}),
        32'({e_req, e_rd, e_rsa, e_rsb, e_alu, e_aop, e_wr, e_idx, e_sel, e_imm}));
    @(posedge clk);
    m_sync_e = 0;
    m_ill    = 0;
    if (m_halted) begin
      halt_cycles++;
    end else if (m_locked && ph != m_nxt) begin
      m_sync_e = 1; m_valid = 0; m_locked = 0;
    end else if (m_locked || ph == 0) begin
      case (ph)
        0: if (rdy) begin m_ir = imem_rdata; m_valid = 1; end else m_valid = 0;
        1: if (m_valid && !legal(op)) begin m_ill = 1; m_valid = 0; end
        2: if (m_valid && op == 5) m_take = zf;
        default: if (m_valid) begin
          m_ret = (m_ret + 1) % 65536;
          if (op == 4 || (op == 5 && m_take)) m_pc = int'(m_ir[7:0]);
          else if (op == 15) m_halted = 1;
          else m_pc = (m_pc + 1) % 256;
        end
      endcase
      m_locked = 1;
      m_nxt    = (ph + 1) % 4;
    end
    tb_ph = (ph + 1) % 4;
    #1;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("ir", 32'(ir), 32'(m_ir));
    chk("flags", 32'({halted, sync_err, illegal_op}), 32'({m_halted, m_sync_e, m_ill}));
    chk("retire_cnt", 32'(retire_cnt), 32'(m_ret));
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit zf);
    repeat (n) step(tb_ph, 1'b1, zf);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    chk_all_zero("reset");
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  function automatic logic [15:0] rand_insn();
    int r;
    logic [3:0] op;
    r = int'($urandom_range(0, 31));
    if (r < 4)       op = 4'h0;
    else if (r < 10) op = 4'h1;
    else if (r < 15) op = 4'h2;
    else if (r < 20) op = 4'h3;
    else if (r < 23) op = 4'h4;
    else if (r < 27) op = 4'h5;
    else if (r < 28) op = 4'hF;
    else             op = 4'(6 + $urandom_range(0, 8));
    return {op, 12'($urandom)};
  endfunction

  initial begin
    resetn = 1'b0; phase = 2'd0; imem_rdata = 16'h0; imem_ready = 1'b0; zero_flag = 1'b0;
    clear_mem();
    model_reset();
    @(negedge clk);
    do_reset();

    // LDI r1,5 ; ADD r2,r1,r1
    mem[0] = 16'h3105; mem[1] = 16'h1211;
    run(8, 1'b0);
    chk("t1_pc", 32'(pc), 32'h02);
    chk("t1_retire", 32'(retire_cnt), 32'd2);

    // Fetch bubble on the second IF, then refetch of address 1
    do_reset();
    run(4, 1'b0);
    step(0, 1'b0, 1'b0); step(1, 1'b1, 1'b0); step(2, 1'b1, 1'b0); step(3, 1'b1, 1'b0);
    chk("t2_pc_hold", 32'(pc), 32'h01);
    chk("t2_retire_hold", 32'(retire_cnt), 32'd1);
    run(4, 1'b0);
    chk("t2_pc_after", 32'(pc), 32'h02);

    // BEQZ taken then not taken, JMP 0xFF, NOP wraps pc
    clear_mem();
    mem[8'h00] = 16'h5020; mem[8'h20] = 16'h5020; mem[8'h21] = 16'h40FF; mem[8'hFF] = 16'h0000;
    do_reset();
    run(4, 1'b1);
    chk("t3_beqz_taken", 32'(pc), 32'h20);
    run(4, 1'b0);
    chk("t3_beqz_not", 32'(pc), 32'h21);
    run(4, 1'b0);
    chk("t3_jmp", 32'(pc), 32'hFF);
    run(4, 1'b0);
    chk("t3_wrap", 32'(pc), 32'h00);

    // Phase skip 1->3 during ADD, then resync and refetch pc 0
    clear_mem();
    mem[0] = 16'h1211;
    do_reset();
    step(0, 1'b1, 1'b0); step(1, 1'b1, 1'b0); step(3, 1'b1, 1'b0);
    chk("t4_sync_err", 32'(sync_err), 32'd1);
    chk("t4_pc", 32'(pc), 32'h00);
    run(4, 1'b0);
    chk("t4_pc_after", 32'(pc), 32'h01);

    // Illegal opcode, then HALT
    mem[0] = 16'h7123;
    do_reset();
    run(4, 1'b0);
    chk("t5_pc_illegal", 32'(pc), 32'h00);
    chk("t5_retire_illegal", 32'(retire_cnt), 32'd0);
    mem[0] = 16'hF000;
    run(4, 1'b0);
    run(24, 1'b0);
    chk("t5_halted", 32'(halted), 32'd1);
    chk("t5_pc_frozen", 32'(pc), 32'h00);

    // Reset asserted during EX of SUB
    mem[0] = 16'h2211;
    do_reset();
    step(0, 1'b1, 1'b0); step(1, 1'b1, 1'b0);
    phase = 2'd2;
    #1;
    do_reset();
    run(4, 1'b0);
    chk("t6_pc", 32'(pc), 32'h01);

    // Randomized programs and phase streams
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < 256; i++) mem[i] = rand_insn();
      do_reset();
      for (int c = 0; c < 600; c++) begin
        int ph;
        ph = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : tb_ph;
        step(ph, ($urandom_range(0, 7) != 0), 1'($urandom));
        if (halt_cycles > 20) do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
